seg_minutes_decoder: RTL and testbench
======================================

// Module: seg_minutes_decoder
// PURPOSE
//   Reverse of the stopwatch minutes segment encoder. Samples a 14-bit two-digit 7-segment bus
//   {tens[6:0], ones[6:0]}, waits for it to hold stable, decodes it back to binary minutes 0..59,
//   and delivers each new value over a valid/ready handshake. Used for display loopback checks
//   and for reading minutes from an external display bus.
// PARAMETERS
//   STABLE_CYCLES  4   consecutive cycles a new pattern must hold before it is decoded (>=1)
// PORTS
//   clk        in   1   single clock, rising edge
//   rst_n      in   1   synchronous, active-low reset
//   seg_in     in   14  {tens,ones}, each digit segments a..g, a at MSB, active-low (0 = lit)
//   min_valid  out  1   minutes holds a decoded value
//   min_ready  in   1   consumer accepts minutes when min_valid&&min_ready
//   minutes    out  6   binary minutes 0..59
//   dec_err    out  1   one-cycle pulse: a stable pattern was illegal
// BEHAVIOUR
//   Reset (rst_n=0 at an edge): state=IDLE, cnt=0, min_valid=0, minutes=0, dec_err=0,
//     seg_q=last_pat=cand=14'h3FFF (all dark). Reset applied mid-SETTLE or mid-EMIT aborts; no output.
//   seg_q: 1-flop input register. All decisions use seg_q, never seg_in.
//   Digit legality: codes 0..9 = 0000001,1001111,0010010,0000110,1001100,0100100,0100000,0001111,
//     0000000,0000100. Tens legal 0..5, ones legal 0..9; every other pattern is illegal.
//   FSM:
//     IDLE   : seg_q!=last_pat -> SETTLE, cand<=seg_q, cnt<=1.
//     SETTLE : seg_q==cand -> cnt<=cnt+1 (saturate); seg_q!=cand && seg_q==last_pat -> IDLE;
//              seg_q!=cand otherwise -> cand<=seg_q, cnt<=1 (restart).
//              cnt==STABLE_CYCLES && seg_q==cand -> decode cand, last_pat<=cand, then:
//                legal   -> EMIT, minutes<=tens*10+ones, min_valid<=1;
//                illegal -> IDLE, dec_err<=1 for exactly one cycle.
//     EMIT   : minutes/min_valid stay constant. seg_q is ignored.
//              min_ready=1 -> min_valid<=0, IDLE. Handshake wins over an input change
//              that arrives in the same cycle; that change is detected from IDLE on the next cycle.
//   Latency: new value first sampled into seg_q at edge N; min_valid (or dec_err) rises at
//     edge N+STABLE_CYCLES+1, i.e. edge 6 for STABLE_CYCLES=4 when seg_in is set before edge 1.
//   An unchanged pattern is never re-emitted or re-flagged. A pattern matching last_pat is ignored.
//   Arithmetic: tens*10+ones is computed at 6 bits (max 59, no overflow). dec_err and min_valid
//     are never high in the same cycle.
// CONFIGURATION
//   SEG_DEC_BLANK_EN defined: tens pattern 1111111 (blank, leading-zero suppression) decodes as 0.
//   SEG_DEC_BLANK_EN undefined: blank tens is illegal and raises dec_err. Blank ones is always illegal.
// STRUCTURE
//   Package seg_dec_pkg: SEG_BLANK constant, SEG_DIGIT[0:9] pattern constants, state typedef
//     {IDLE,SETTLE,EMIT}.
//   Sub-module seg7_digit_decode: combinational, 7-bit pattern -> {legal, digit[3:0]}. Instanced
//     twice (tens, ones). Tens range check and blank handling stay in the parent.
// TESTING  (STABLE_CYCLES=4, min_ready=1 unless stated)
//   1 reset; seg_in=0010010_0100100 ("25") held -> min_valid one cycle after edge 6, minutes=25;
//     pattern held 20 more cycles -> no further min_valid.
//   2 "13" held 2 cycles then "14" held -> single emission minutes=14, never 13, no dec_err.
//   3 0100000_0000001 (tens=6) held -> single dec_err pulse, min_valid stays 0; same pattern held
//     or re-sampled -> no new pulse.
//   4 min_ready=0; "59" emitted, then seg_in="00" -> min_valid=1, minutes=59 held for 10 cycles;
//     min_ready=1 -> handshake, then minutes=0 valid 5 edges after the handshake edge.
//   5 rst_n=0 for one edge while in SETTLE on "42", then "42" held -> no output during reset;
//     minutes=42 emitted 6 edges after reset release.
//   6 1111111_0000110 held -> SEG_DEC_BLANK_EN: minutes=3; without macro: dec_err pulse, no valid.

Source files
------------

// File: rtl/seg_dec_pkg.sv
// rtl/seg_dec_pkg.sv - shared constants and state type for the minutes segment decoder
// Contents: SEG_BLANK (all segments dark), SEG_DIGIT[0:9] active-low a..g patterns,
//           state_t {IDLE, SETTLE, EMIT}.
package seg_dec_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
   };

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      EMIT
   } state_t;

endpackage

// File: rtl/seg_minutes_decoder_if.sv
// rtl/seg_minutes_decoder_if.sv - segment input bus and minutes handshake bundle
// Signals: seg_in[13:0] {tens,ones} active-low segments, min_valid/min_ready handshake,
//          minutes[5:0] decoded value, dec_err one-cycle illegal-pattern pulse.
// Modports: master = decoder side, slave = display source / consumer side.
interface seg_minutes_decoder_if;

   logic [13:0] seg_in;
   logic        min_valid;
   logic        min_ready;
   logic [5:0]  minutes;
   logic        dec_err;

   modport master (
      input  seg_in,
      input  min_ready,
      output min_valid,
      output minutes,
      output dec_err
   );

   modport slave (
      output seg_in,
      output min_ready,
      input  min_valid,
      input  minutes,
      input  dec_err
   );

endinterface

// File: rtl/seg7_digit_decode.sv
// rtl/seg7_digit_decode.sv - combinational 7-segment pattern to BCD digit lookup
// Ports: pat[6:0] in (a..g, a at MSB, active-low), legal out (pattern is a digit 0..9),
//        digit[3:0] out (decoded value, 0 when not legal).
module seg7_digit_decode
   import seg_dec_pkg::*;
(
   input  logic [6:0] pat,
   output logic       legal,
   output logic [3:0] digit
);

   always_comb begin
      legal = 1'b0;
      digit = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (pat == SEG_DIGIT[i]) begin
            legal = 1'b1;
            digit = 4'(i);
         end
      end
   end

endmodule

// File: rtl/seg_minutes_decoder.sv
// rtl/seg_minutes_decoder.sv - debounced two-digit 7-segment to binary minutes decoder
// Ports: clk (rising edge), rst_n (synchronous, active-low),
//        bus (seg_minutes_decoder_if.master): seg_in, min_valid, min_ready, minutes, dec_err.
// Parameter: STABLE_CYCLES (>=1) cycles a new pattern must hold before it is decoded.
// Build option: SEG_DEC_BLANK_EN - a blank tens digit decodes as 0 instead of being illegal.
module seg_minutes_decoder
   import seg_dec_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
)
(
   input  logic                         clk,
   input  logic                         rst_n,
   seg_minutes_decoder_if.master        bus
);

   localparam int             CW      = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [13:0]    seg_q, seg_d;
   logic [13:0]    last_pat_q, last_pat_d;
   logic [13:0]    cand_q, cand_d;
   logic           min_valid_q, min_valid_d;
   logic [5:0]     minutes_q, minutes_d;
   logic           dec_err_q, dec_err_d;

   logic           t_legal, o_legal;
   logic [3:0]     t_digit, o_digit;
   logic           tens_ok, pat_legal;
   logic [3:0]     tens_val;
   logic [5:0]     pat_minutes;

   seg7_digit_decode u_tens (.pat(cand_q[13:7]), .legal(t_legal), .digit(t_digit));
   seg7_digit_decode u_ones (.pat(cand_q[6:0]),  .legal(o_legal), .digit(o_digit));

   // Decoding always looks at cand_q: at the decision point it equals seg_q.
   always_comb begin
      tens_ok  = t_legal && (t_digit <= 4'd5);
      tens_val = t_digit;
`ifdef SEG_DEC_BLANK_EN
      if (cand_q[13:7] == SEG_BLANK) begin
         tens_ok  = 1'b1;
         tens_val = 4'd0;
      end
`endif
      pat_legal   = tens_ok && o_legal;
      pat_minutes = {2'b00, tens_val} * 6'd10 + {2'b00, o_digit};
   end

   assign seg_d = bus.seg_in;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cand_d      = cand_q;
      last_pat_d  = last_pat_q;
      min_valid_d = min_valid_q;
      minutes_d   = minutes_q;
      dec_err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (seg_q != last_pat_q) begin
               state_d = SETTLE;
               cand_d  = seg_q;
               cnt_d   = CW'(1);
            end
         end
         SETTLE: begin
            if (seg_q == cand_q) begin
               if (cnt_q == CNT_MAX) begin
                  // Illegal patterns are also remembered so they are flagged only once.
                  last_pat_d = cand_q;
                  if (pat_legal) begin
                     state_d     = EMIT;
                     minutes_d   = pat_minutes;
                     min_valid_d = 1'b1;
                  end else begin
                     state_d   = IDLE;
                     dec_err_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else if (seg_q == last_pat_q) begin
               // Glitch back to the already-reported pattern: nothing new to report.
               state_d = IDLE;
            end else begin
               cand_d = seg_q;
               cnt_d  = CW'(1);
            end
         end
         EMIT: begin
            // Input changes here are picked up from IDLE after the handshake.
            if (bus.min_ready) begin
               min_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         seg_q       <= 14'h3FFF;
         last_pat_q  <= 14'h3FFF;
         cand_q      <= 14'h3FFF;
         min_valid_q <= 1'b0;
         minutes_q   <= 6'd0;
         dec_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         seg_q       <= seg_d;
         last_pat_q  <= last_pat_d;
         cand_q      <= cand_d;
         min_valid_q <= min_valid_d;
         minutes_q   <= minutes_d;
         dec_err_q   <= dec_err_d;
      end
   end

   assign bus.min_valid = min_valid_q;
   assign bus.minutes   = minutes_q;
   assign bus.dec_err   = dec_err_q;

endmodule

// File: tb/tb_seg_minutes_decoder.sv
// tb/tb_seg_minutes_decoder.sv - self-checking bench for seg_minutes_decoder
// Honours SEG_DEC_BLANK_EN the same way as the design.
module tb_seg_minutes_decoder;

   localparam int S = 4;

   logic clk;
   logic rst_n;

   seg_minutes_decoder_if bus_if ();

   seg_minutes_decoder #(.STABLE_CYCLES(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] dig(input int d);
      case (d)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [13:0] pat2(input int t, input int o);
      return {dig(t), dig(o)};
   endfunction

   function automatic int digit_of(input logic [6:0] p);
      for (int i = 0; i < 10; i++) if (dig(i) == p) return i;
      return -1;
   endfunction

   // Reference: a new pattern is reported once it has been seen in seg_q on S+1
   // consecutive non-busy edges; busy means a value is waiting for the consumer.
   logic [13:0] m_seg, m_last, m_cand;
   int          m_run;
   logic        m_valid, m_err;
   logic [5:0]  m_min;

   task automatic model_step();
      int  t, o;
      logic legal, err_n;
      if (!rst_n) begin
         m_seg = 14'h3FFF; m_last = 14'h3FFF; m_cand = 14'h3FFF;
         m_run = 0; m_valid = 1'b0; m_err = 1'b0; m_min = 6'd0;
      end else begin
         err_n = 1'b0;
         if (m_valid) begin
            if (bus_if.min_ready) m_valid = 1'b0;
         end else begin
            if (m_seg == m_last) m_run = 0;
            else if (m_run > 0 && m_seg == m_cand) m_run++;
            else begin m_cand = m_seg; m_run = 1; end
            if (m_run == S + 1) begin
               t = digit_of(m_cand[13:7]);
               o = digit_of(m_cand[6:0]);
`ifdef SEG_DEC_BLANK_EN
               if (m_cand[13:7] == 7'b1111111) t = 0;
`endif
               legal = (t >= 0) && (t <= 5) && (o >= 0);
               if (legal) begin m_valid = 1'b1; m_min = 6'(t * 10 + o); end
               else err_n = 1'b1;
               m_last = m_cand;
               m_run  = 0;
            end
         end
         m_err = err_n;
         m_seg = bus_if.seg_in;
      end
   endtask

   always @(posedge clk) model_step();

   int         n_rise, n_errp;
   logic [5:0] last_min;
   logic       prev_valid = 1'b0;

   always @(negedge clk) begin
      check("min_valid", 32'(bus_if.min_valid), 32'(m_valid));
      check("dec_err",   32'(bus_if.dec_err),   32'(m_err));
      check("minutes",   32'(bus_if.minutes),   32'(m_min));
      check("valid_and_err", 32'(bus_if.min_valid & bus_if.dec_err), 32'd0);
      if (bus_if.min_valid && !prev_valid) begin
         n_rise++;
         last_min = bus_if.minutes;
      end
      if (bus_if.dec_err) n_errp++;
      prev_valid = bus_if.min_valid;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic hold_reset();
      rst_n = 1'b0;
      bus_if.seg_in = 14'h3FFF;
      bus_if.min_ready = 1'b1;
      step(2);
      n_rise = 0;
      n_errp = 0;
   endtask

   initial begin
      int kind, hold, tv, ov;
      logic [13:0] pat;
      rst_n = 1'b0;
      bus_if.seg_in = 14'h3FFF;
      bus_if.min_ready = 1'b1;
      n_rise = 0; n_errp = 0; last_min = 6'd0;

      // 1: reset state, latency, no re-emission
      hold_reset();
      check("rst_valid", 32'(bus_if.min_valid), 32'd0);
      check("rst_minutes", 32'(bus_if.minutes), 32'd0);
      check("rst_err", 32'(bus_if.dec_err), 32'd0);
      rst_n = 1'b1; bus_if.seg_in = 14'b0010010_0100100;
      step(5);
      check("t1_edge5_valid", 32'(bus_if.min_valid), 32'd0);
      step(1);
      check("t1_edge6_valid", 32'(bus_if.min_valid), 32'd1);
      check("t1_minutes", 32'(bus_if.minutes), 32'd25);
      step(21);
      check("t1_emissions", 32'(n_rise), 32'd1);

      // 2: short-lived "13" is superseded by "14"
      hold_reset();
      rst_n = 1'b1; bus_if.seg_in = pat2(1, 3);
      step(2);
      bus_if.seg_in = pat2(1, 4);
      step(20);
      check("t2_emissions", 32'(n_rise), 32'd1);
      check("t2_minutes", 32'(last_min), 32'd14);
      check("t2_errors", 32'(n_errp), 32'd0);

      // 3: tens=6 flagged once, not re-flagged
      hold_reset();
      rst_n = 1'b1; bus_if.seg_in = 14'b0100000_0000001;
      step(20);
      check("t3_errors", 32'(n_errp), 32'd1);
      check("t3_emissions", 32'(n_rise), 32'd0);
      bus_if.seg_in = 14'h3FFF;
      step(2);
      bus_if.seg_in = 14'b0100000_0000001;
      step(20);
      check("t3_errors_again", 32'(n_errp), 32'd1);

      // 4: back-pressure holds 59, then "00" follows the handshake
      hold_reset();
      bus_if.min_ready = 1'b0;
      rst_n = 1'b1; bus_if.seg_in = pat2(5, 9);
      step(7);
      bus_if.seg_in = pat2(0, 0);
      step(10);
      check("t4_held_valid", 32'(bus_if.min_valid), 32'd1);
      check("t4_held_minutes", 32'(bus_if.minutes), 32'd59);
      bus_if.min_ready = 1'b1;
      step(1);
      check("t4_after_hs", 32'(bus_if.min_valid), 32'd0);
      step(4);
      check("t4_hs4_valid", 32'(bus_if.min_valid), 32'd0);
      step(1);
      check("t4_hs5_valid", 32'(bus_if.min_valid), 32'd1);
      check("t4_hs5_minutes", 32'(bus_if.minutes), 32'd0);

      // 5: reset during settling aborts, then restarts from scratch
      hold_reset();
      rst_n = 1'b1; bus_if.seg_in = pat2(4, 2);
      step(3);
      rst_n = 1'b0;
      step(1);
      check("t5_in_reset", 32'(bus_if.min_valid), 32'd0);
      rst_n = 1'b1;
      step(5);
      check("t5_edge5_valid", 32'(bus_if.min_valid), 32'd0);
      step(1);
      check("t5_edge6_valid", 32'(bus_if.min_valid), 32'd1);
      check("t5_minutes", 32'(bus_if.minutes), 32'd42);

      // 6: blank tens digit
      hold_reset();
      rst_n = 1'b1; bus_if.seg_in = {7'b1111111, 7'b0000110};
      step(6);
`ifdef SEG_DEC_BLANK_EN
      check("t6_valid", 32'(bus_if.min_valid), 32'd1);
      check("t6_minutes", 32'(bus_if.minutes), 32'd3);
      step(1);
      check("t6_errors", 32'(n_errp), 32'd0);
`else
      check("t6_valid", 32'(bus_if.min_valid), 32'd0);
      step(1);
      check("t6_errors", 32'(n_errp), 32'd1);
`endif

      // Randomised traffic against the reference
      pat = 14'h3FFF;
      for (int it = 0; it < 400; it++) begin
         kind = int'($urandom_range(0, 9));
         tv = int'($urandom_range(0, 5));
         ov = int'($urandom_range(0, 9));
         case (kind)
            0, 1, 2, 3, 4, 5: pat = pat2(tv, ov);
            6: pat = pat2(int'($urandom_range(6, 9)), ov);
            7: pat = 14'($urandom);
            8: pat = {7'b1111111, dig(ov)};
            default: ;
         endcase
         bus_if.seg_in = pat;
         if ($urandom_range(0, 49) == 0) rst_n = 1'b0;
         hold = int'($urandom_range(1, 8));
         for (int c = 0; c < hold; c++) begin
            bus_if.min_ready = ($urandom_range(0, 9) < 7);
            step(1);
            rst_n = 1'b1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
